icache_fetch: RTL and testbench
===============================

ICACHE_FETCH -- requirements
Module: icache_fetch

Interface
REQ-001 Parameter ADDR_W, default 32, instruction address width in bits.
REQ-002 Parameter DATA_W, default 32, instruction and memory word width in bits.
REQ-003 Parameter LINES, default 16, number of direct-mapped lines; SHALL be a power of two, at least 2.
REQ-004 Parameter WORDS, default 4, words per line; SHALL be a power of two, at least 2.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 pc_ce  in  1  fetch request from PC, valid this cycle.
REQ-008 pc_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
REQ-009 stall  in  1  staller hold; no request accepted and no delivery made while high.
REQ-010 dec_enable  out  1  one-cycle pulse: dec_inst and dec_addr valid.
REQ-011 dec_inst  out  DATA_W  delivered instruction word.
REQ-012 dec_addr  out  ADDR_W  address of the delivered instruction, word-aligned.
REQ-013 sta_enable  out  1  cache idle and able to accept a request this cycle.
REQ-014 mem_req  out  1  refill beat request to instruction memory.
REQ-015 mem_addr  out  ADDR_W  word-aligned byte address of the requested beat.
REQ-016 mem_valid  in  1  memory returns mem_data for the current beat.
REQ-017 mem_data  in  DATA_W  refill data word.

Function
REQ-018 Address split: word offset is pc_addr[log2(WORDS)+1:2]; index is the next log2(LINES) bits; tag is the remaining upper bits.
REQ-019 Per-line storage: valid bit, tag, and WORDS data words.
REQ-020 States: IDLE, REFILL, RESPOND.
REQ-021 Request acceptance: a request is accepted only in IDLE with pc_ce=1 and stall=0.
REQ-022 On acceptance, the cache latches the request address into req_addr.
REQ-023 sta_enable SHALL be 1 in IDLE and 0 in REFILL and RESPOND.
REQ-024 Hit: accepted request, index valid, tag match -> the next cycle drives dec_enable=1, dec_inst=stored word, dec_addr={req_addr[ADDR_W-1:2],2'b00}; state stays IDLE. Hit latency is 1 cycle.
REQ-025 Miss: accepted request, line invalid or tag mismatch -> state goes to REFILL with beat counter=0; dec_enable stays 0.
REQ-026 REFILL drives mem_req=1 and mem_addr=line base + beat*4, where line base is req_addr with offset and byte bits cleared.
REQ-027 REFILL, per mem_valid=1 cycle: writes mem_data into word[beat] of the indexed line; beat increments and wraps modulo WORDS.
REQ-028 REFILL completion: on the mem_valid that delivers beat WORDS-1, the line's tag is written, its valid bit is set, and state goes to RESPOND; mem_req drops the following cycle.
REQ-029 REFILL invalidation: the line's valid bit is cleared on entry to REFILL and stays cleared until completion.
REQ-030 REFILL ignores stall; refill beats proceed while stall=1.
REQ-031 RESPOND with stall=0: drives dec_enable=1 with the requested word and dec_addr the next cycle, then state goes to IDLE.
REQ-032 RESPOND with stall=1: the cache waits in RESPOND and makes no delivery.
REQ-033 dec_enable is high for exactly one cycle per accepted request; dec_inst and dec_addr hold their last value while dec_enable=0.
REQ-034 Deliveries are in request order; at most one request is outstanding.
REQ-035 mem_valid outside REFILL is ignored.
REQ-036 pc_ce outside IDLE is ignored; PC re-presents the request.

Reset
REQ-037 rst=0 asynchronously forces: state IDLE, all valid bits 0, beat counter 0, dec_enable 0, dec_inst 0, dec_addr 0, mem_req 0, mem_addr 0.
REQ-038 rst=0 forces sta_enable to 1 once reset releases.
REQ-039 Reset asserted mid-REFILL aborts the refill with no line left valid.
REQ-040 Data array contents need not be reset.

Verification
REQ-041 Cold miss: reset; pc_ce=1, pc_addr=0x00000104; memory returns 0xA0,0xA1,0xA2,0xA3 -> mem_addr sequence 0x100,0x104,0x108,0x10C; dec_enable=1 once with dec_inst=0xA1, dec_addr=0x104.
REQ-042 Hit after fill: pc_addr=0x10C -> dec_enable exactly 1 cycle after acceptance, dec_inst=0xA3, mem_req stays 0.
REQ-043 Conflict eviction: fetch 0x104 to fill the line, then fetch 0x504 (same index, LINES=16, WORDS=4) -> refill occurs; a subsequent 0x104 misses again.
REQ-044 Stall: stall=1 during REFILL -> beats proceed and the cache holds in RESPOND; after stall=0, dec_enable pulses the next cycle; pc_ce with stall=1 in IDLE -> no acceptance.
REQ-045 Reset mid-refill: rst=0 after beat 2 -> mem_req=0 immediately; after release, the same address misses and performs a full 4-beat refill.
REQ-046 Slow memory: mem_valid gaps of 0 to 3 cycles between beats -> correct word order and a single dec_enable pulse.

Source files
------------

// File: rtl/icache_fetch_if.sv
// Fetch-side bundle of the instruction cache: PC request, decoder delivery,
// and the refill port to instruction memory.
interface icache_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              pc_ce;
    logic [ADDR_W-1:0] pc_addr;
    logic              stall;
    logic              dec_enable;
    logic [DATA_W-1:0] dec_inst;
    logic [ADDR_W-1:0] dec_addr;
    logic              sta_enable;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output pc_ce, pc_addr, stall, mem_valid, mem_data,
        input  dec_enable, dec_inst, dec_addr, sta_enable, mem_req, mem_addr
    );

    modport slave (
        input  pc_ce, pc_addr, stall, mem_valid, mem_data,
        output dec_enable, dec_inst, dec_addr, sta_enable, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped, blocking instruction cache: 1-cycle hits, sequential
// line refill from beat 0, single outstanding request.
module icache_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 16,
    parameter int WORDS  = 4
) (
    input  logic          clk,
    input  logic          rst,
    icache_fetch_if.slave bus
);
    localparam int OFF_W   = $clog2(WORDS);
    localparam int IDX_W   = $clog2(LINES);
    localparam int LSB_IDX = OFF_W + 2;
    localparam int LSB_TAG = IDX_W + OFF_W + 2;
    localparam int TAG_W   = ADDR_W - LSB_TAG;

    typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

    state_t            state;
    logic [ADDR_W-1:0] req_addr;
    logic [OFF_W-1:0]  beat;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES*WORDS];

    logic [OFF_W-1:0]  pc_off, req_off, beat_nxt;
    logic [IDX_W-1:0]  pc_idx, req_idx;
    logic [TAG_W-1:0]  pc_tag, req_tag;
    logic              accept, pc_hit, last_beat;
    logic              unused_lsb;

    assign pc_off   = bus.pc_addr[LSB_IDX-1:2];
    assign pc_idx   = bus.pc_addr[LSB_TAG-1:LSB_IDX];
    assign pc_tag   = bus.pc_addr[ADDR_W-1:LSB_TAG];
    assign req_off  = req_addr[LSB_IDX-1:2];
    assign req_idx  = req_addr[LSB_TAG-1:LSB_IDX];
    assign req_tag  = req_addr[ADDR_W-1:LSB_TAG];
    assign beat_nxt = beat + OFF_W'(1);
    assign last_beat = (beat == OFF_W'(WORDS - 1));
    assign unused_lsb = ^req_addr[1:0];

    assign accept = (state == IDLE) && bus.pc_ce && !bus.stall;
    assign pc_hit = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide
    // whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (state == REFILL && bus.mem_valid) begin
            data_mem[{req_idx, beat}] <= bus.mem_data;
            if (last_beat) tag_mem[req_idx] <= req_tag;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every branch sees
    // the pre-edge values of state, beat and req_addr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            req_addr       <= '0;
            beat           <= '0;
            valid_q        <= '0;
            bus.sta_enable <= 1'b1;
            bus.dec_enable <= 1'b0;
            bus.dec_inst   <= '0;
            bus.dec_addr   <= '0;
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= '0;
        end else begin
            bus.dec_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_addr <= bus.pc_addr;
                        if (pc_hit) begin
                            bus.dec_enable <= 1'b1;
                            bus.dec_inst   <= data_mem[{pc_idx, pc_off}];
                            bus.dec_addr   <= {bus.pc_addr[ADDR_W-1:2], 2'b00};
                        end else begin
                            // The line is unusable until its last beat lands.
                            state           <= REFILL;
                            bus.sta_enable  <= 1'b0;
                            beat            <= '0;
                            valid_q[pc_idx] <= 1'b0;
                            bus.mem_req     <= 1'b1;
                            bus.mem_addr    <= {bus.pc_addr[ADDR_W-1:LSB_IDX], {(OFF_W+2){1'b0}}};
                        end
                    end
                end
                REFILL: begin
                    if (bus.mem_valid) begin
                        beat         <= beat_nxt;
                        bus.mem_addr <= {req_addr[ADDR_W-1:LSB_IDX], beat_nxt, 2'b00};
                        if (last_beat) begin
                            valid_q[req_idx] <= 1'b1;
                            bus.mem_req      <= 1'b0;
                            state            <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    if (!bus.stall) begin
                        bus.dec_enable <= 1'b1;
                        bus.dec_inst   <= data_mem[{req_idx, req_off}];
                        bus.dec_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
                        bus.sta_enable <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.sta_enable <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: memory responder, delivery scoreboard and
// a line-level hit/miss model, plus literal checks from hand-worked examples.
module tb_icache_fetch;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    icache_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    icache_fetch #(.ADDR_W(AW), .DATA_W(DW), .LINES(16), .WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } deliv_t;

    int          total = 0;
    int          bad = 0;
    deliv_t      sb[$];
    logic [31:0] addr_log[$];
    int          beats_given = 0;
    int          waited = 0;
    int          dec_count = 0;
    int          gap_tbl[4] = '{0, 0, 0, 0};
    bit          spur_en = 1'b0;
    logic [31:0] exp_base = '0;
    logic [31:0] last_inst = '0;
    logic [31:0] last_addr = '0;
    bit          model_valid[16];
    logic [23:0] model_tag[16];

    // Memory image: line 0x100 holds 0xA0..0xA3, everything else is addr-tagged.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h10) return 32'hA0 + {30'd0, a[3:2]};
        return 32'hD000_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Compare process and memory responder, both on the falling edge.
    initial begin
        deliv_t e;
        bus.mem_valid = 1'b0;
        bus.mem_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_inst     = '0;
                last_addr     = '0;
                beats_given   = 0;
                waited        = 0;
                bus.mem_valid = 1'b0;
            end else begin
                if (bus.dec_enable) begin
                    dec_count++;
                    if (sb.size() == 0) begin
                        check("unexpected dec_enable", {31'd0, bus.dec_enable}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("dec_inst", bus.dec_inst, e.inst);
                        check("dec_addr", bus.dec_addr, e.addr);
                    end
                    last_inst = bus.dec_inst;
                    last_addr = bus.dec_addr;
                end else begin
                    check("dec_inst hold", bus.dec_inst, last_inst);
                    check("dec_addr hold", bus.dec_addr, last_addr);
                end
                if (bus.mem_req) begin
                    if (beats_given >= 4) begin
                        check("mem_req after last beat", {31'd0, bus.mem_req}, 32'd0);
                        bus.mem_valid = 1'b0;
                    end else begin
                        check("mem_addr", bus.mem_addr, exp_base + 32'(4 * beats_given));
                        if (waited >= gap_tbl[beats_given]) begin
                            bus.mem_valid = 1'b1;
                            bus.mem_data  = mem_word(exp_base + 32'(4 * beats_given));
                            addr_log.push_back(bus.mem_addr);
                            beats_given++;
                            waited = 0;
                        end else begin
                            bus.mem_valid = 1'b0;
                            bus.mem_data  = 32'hBAD0_0000;
                            waited++;
                        end
                    end
                end else begin
                    beats_given   = 0;
                    waited        = 0;
                    bus.mem_valid = spur_en;
                    bus.mem_data  = spur_en ? 32'hDEAD_BEEF : 32'h0;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a);
        int          idx = int'((a >> 4) & 32'hF);
        logic [23:0] tag = a[31:8];
        bit          hit;
        int          n = 0;
        while (!bus.sta_enable && n < 100) begin
            tick();
            n++;
        end
        check("sta_enable before issue", {31'd0, bus.sta_enable}, 32'd1);
        hit = model_valid[idx] && (model_tag[idx] == tag);
        sb.push_back('{addr: a & ~32'h3, inst: mem_word(a & ~32'h3)});
        if (!hit) begin
            exp_base = a & ~32'hF;
            addr_log.delete();
            model_valid[idx] = 1'b1;
            model_tag[idx]   = tag;
        end
        bus.pc_ce   = 1'b1;
        bus.pc_addr = a;
        tick();
        bus.pc_ce   = 1'b0;
        bus.pc_addr = 32'hFFFF_FFFC;
        if (hit) begin
            check("hit latency dec_enable", {31'd0, bus.dec_enable}, 32'd1);
            check("hit mem_req", {31'd0, bus.mem_req}, 32'd0);
        end else begin
            check("miss mem_req", {31'd0, bus.mem_req}, 32'd1);
            check("miss dec_enable", {31'd0, bus.dec_enable}, 32'd0);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check("delivery pending at timeout", sb.size(), 32'd0);
    endtask

    task automatic check_log(input logic [31:0] base);
        check("refill beat count", addr_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_log.size()) check("refill beat addr", addr_log[i], base + 32'(4 * i));
        end
    endtask

    initial begin
        int d0;
        int n;
        bus.pc_ce   = 1'b0;
        bus.pc_addr = '0;
        bus.stall   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            model_valid[i] = 1'b0;
            model_tag[i]   = '0;
        end

        // Reset values
        repeat (3) tick();
        check("reset dec_enable", {31'd0, bus.dec_enable}, 32'd0);
        check("reset dec_inst", bus.dec_inst, 32'd0);
        check("reset dec_addr", bus.dec_addr, 32'd0);
        check("reset mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("reset mem_addr", bus.mem_addr, 32'd0);
        rst = 1'b1;
        tick();
        check("sta_enable after reset", {31'd0, bus.sta_enable}, 32'd1);

        // Cold miss
        d0 = dec_count;
        issue(32'h104);
        wait_done();
        repeat (3) tick();
        check_log(32'h100);
        check("cold dec_inst", last_inst, 32'hA1);
        check("cold dec_addr", last_addr, 32'h104);
        check("cold pulse count", dec_count - d0, 32'd1);

        // Hit after fill
        addr_log.delete();
        issue(32'h10C);
        check("hit dec_inst", bus.dec_inst, 32'hA3);
        repeat (3) begin
            tick();
            check("hit no refill", {31'd0, bus.mem_req}, 32'd0);
        end
        check("hit no beats", addr_log.size(), 32'd0);

        // Conflict eviction on index 0
        issue(32'h504);
        wait_done();
        check_log(32'h500);
        issue(32'h104);
        wait_done();
        check_log(32'h100);

        // Stall during refill, then hold in RESPOND
        issue(32'h208);
        bus.stall = 1'b1;
        n = 0;
        while (bus.mem_req && n < 100) begin
            tick();
            n++;
        end
        check("refill under stall finished", {31'd0, bus.mem_req}, 32'd0);
        check_log(32'h200);
        repeat (3) begin
            tick();
            check("stall hold dec_enable", {31'd0, bus.dec_enable}, 32'd0);
            check("stall hold sta_enable", {31'd0, bus.sta_enable}, 32'd0);
        end
        bus.stall = 1'b0;
        tick();
        check("stall release dec_enable", {31'd0, bus.dec_enable}, 32'd1);
        check("stall release sta_enable", {31'd0, bus.sta_enable}, 32'd1);

        // Stall in IDLE blocks acceptance
        bus.stall   = 1'b1;
        bus.pc_ce   = 1'b1;
        bus.pc_addr = 32'h504;
        repeat (3) begin
            tick();
            check("idle stall mem_req", {31'd0, bus.mem_req}, 32'd0);
            check("idle stall dec_enable", {31'd0, bus.dec_enable}, 32'd0);
            check("idle stall sta_enable", {31'd0, bus.sta_enable}, 32'd1);
        end
        bus.pc_ce = 1'b0;
        bus.stall = 1'b0;

        // Stray mem_valid outside REFILL must not touch the array
        spur_en = 1'b1;
        issue(32'h20C);
        tick();
        issue(32'h200);
        repeat (2) tick();
        spur_en = 1'b0;
        check("stray beat dec_inst", last_inst, 32'hD000_0200);

        // Reset in the middle of a refill
        issue(32'h344);
        n = 0;
        while (beats_given < 2 && n < 100) begin
            tick();
            n++;
        end
        check("beats before abort", beats_given, 32'd2);
        rst = 1'b0;
        #1;
        check("abort mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("abort dec_enable", {31'd0, bus.dec_enable}, 32'd0);
        sb.delete();
        for (int i = 0; i < 16; i++) model_valid[i] = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("sta_enable after abort", {31'd0, bus.sta_enable}, 32'd1);
        issue(32'h344);
        wait_done();
        check_log(32'h340);
        issue(32'h20C);
        wait_done();
        check_log(32'h200);

        // Slow memory with gaps between beats
        gap_tbl = '{2, 0, 3, 1};
        d0 = dec_count;
        issue(32'h7F8);
        wait_done();
        repeat (3) tick();
        check_log(32'h7F0);
        check("slow pulse count", dec_count - d0, 32'd1);
        check("slow dec_inst", last_inst, 32'hD000_07F8);
        check("slow dec_addr", last_addr, 32'h7F8);
        gap_tbl = '{0, 0, 0, 0};

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
